// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and the
// stall/flush controller. master = pipeline datapath, slave = controller.
//
// Handshake: the MEM stage raises mem_req while a data access is pending and
// keeps it up until the cycle in which data memory returns mem_ready=1; that
// cycle completes the access. The multi-cycle unit works the same way:
// ex_multi_start stays up until the cycle with ex_multi_done=1.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5
) ();
  logic [REG_W-1:0] id_rs1_idx;
  logic [REG_W-1:0] id_rs2_idx;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd_idx;
  logic             ex_load;
  logic             ex_multi_start;
  logic             ex_multi_done;
  logic             mem_req;
  logic             mem_ready;
  logic             redirect;
  logic             pc_hold;
  logic             if_id_hold;
  logic             id_ex_hold;
  logic             ex_mem_hold;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             stall_timeout;

  modport master (
    output id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, ex_rd_idx,
           ex_load, ex_multi_start, ex_multi_done, mem_req, mem_ready,
           redirect,
    input  pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush,
           id_ex_flush, ex_mem_flush, mem_wb_flush, stall_timeout
  );

  modport slave (
    input  id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used, ex_rd_idx,
           ex_load, ex_multi_start, ex_multi_done, mem_req, mem_ready,
           redirect,
    output pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush,
           id_ex_flush, ex_mem_flush, mem_wb_flush, stall_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubbles,
// data-memory waits, multi-cycle execute waits, branch redirects and a sticky
// stall-timeout watchdog. Hold/flush outputs are Mealy (state + inputs).
// Optional macro PIPE_HAZARD_PERF_EN adds four 32-bit event counters.
module pipe_hazard_ctrl #(
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 256,
  parameter int TMR_W   = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.slave    hz,
  output logic [1:0]           dbg_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]          perf_lu_cnt,
  output logic [31:0]          perf_mem_cnt,
  output logic [31:0]          perf_exec_cnt,
  output logic [31:0]          perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    EXEC_WAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] wait_cnt;
  logic             timeout_q;

  logic [REG_W-1:0] rs1_idx;
  logic [REG_W-1:0] rs2_idx;
  logic [REG_W-1:0] rd_idx;
  logic             mem_stall;
  logic             exec_stall;
  logic             lu;

  // Chosen action for this cycle; exactly one (or none) is set.
  logic do_mem;
  logic do_exec;
  logic do_red;
  logic do_lu;
  logic stall_persist;

  assign rs1_idx    = hz.id_rs1_idx;
  assign rs2_idx    = hz.id_rs2_idx;
  assign rd_idx     = hz.ex_rd_idx;
  assign mem_stall  = hz.mem_req & ~hz.mem_ready;
  assign exec_stall = hz.ex_multi_start & ~hz.ex_multi_done;
  assign lu = hz.ex_load & (rd_idx != '0) &
              ((hz.id_rs1_used & (rs1_idx == rd_idx)) |
               (hz.id_rs2_used & (rs2_idx == rd_idx)));

  // Priority resolution per state; release cycles fall back to the RUN rules
  // that are still meaningful (redirect is only honoured outside a wait).
  always_comb begin
    do_mem        = 1'b0;
    do_exec       = 1'b0;
    do_red        = 1'b0;
    do_lu         = 1'b0;
    stall_persist = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall)          do_mem  = 1'b1;
        else if (exec_stall)    do_exec = 1'b1;
        else if (hz.redirect)   do_red  = 1'b1;
        else if (lu)            do_lu   = 1'b1;
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          do_mem        = 1'b1;
          stall_persist = 1'b1;
        end
        else if (exec_stall)    do_exec = 1'b1;
        else if (hz.redirect)   do_red  = 1'b1;
        else if (lu)            do_lu   = 1'b1;
      end
      EXEC_WAIT: begin
        if (mem_stall) begin
          do_mem        = 1'b1;
          stall_persist = 1'b1;
        end
        else if (!hz.ex_multi_done) begin
          do_exec       = 1'b1;
          stall_persist = 1'b1;
        end
        else if (hz.redirect)   do_red  = 1'b1;
        else if (lu)            do_lu   = 1'b1;
      end
      default: ;
    endcase
    state_nxt = do_mem ? MEM_WAIT : (do_exec ? EXEC_WAIT : RUN);
  end

  // Mealy outputs, forced low while reset is asserted.
  always_comb begin
    hz.pc_hold      = rst & (do_mem | do_exec | do_lu);
    hz.if_id_hold   = rst & (do_mem | do_exec | do_lu);
    hz.id_ex_hold   = rst & (do_mem | do_exec);
    hz.ex_mem_hold  = rst & do_mem;
    hz.if_id_flush  = rst & do_red;
    hz.id_ex_flush  = rst & (do_red | do_lu);
    hz.ex_mem_flush = rst & do_exec;
    hz.mem_wb_flush = rst & do_mem;
  end

  assign hz.stall_timeout = timeout_q;
  assign dbg_state        = state;

  // State, saturating wait counter and sticky watchdog flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end
    else begin
      state <= state_nxt;
      if (state == RUN || state_nxt != state)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
      if (stall_persist && wait_cnt == TMR_W'(TIMEOUT - 1))
        timeout_q <= 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Event counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_cnt    <= '0;
      perf_mem_cnt   <= '0;
      perf_exec_cnt  <= '0;
      perf_flush_cnt <= '0;
    end
    else begin
      if (do_lu)   perf_lu_cnt    <= perf_lu_cnt + 32'd1;
      if (do_mem)  perf_mem_cnt   <= perf_mem_cnt + 32'd1;
      if (do_exec) perf_exec_cnt  <= perf_exec_cnt + 32'd1;
      if (do_red)  perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
